// File: rtl/dds_rom_arbiter_pkg.sv
// Shared constants and helpers for the DDS ROM arbiter and its ROM neighbour.
`default_nettype none

package dds_rom_arbiter_pkg;

  localparam int DDS_PHASE_WIDTH = 12;
  localparam int DDS_ROM_WIDTH   = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // Channel tag width; a single channel still needs one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dds_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
`default_nettype none

module dds_rr_arb
  import dds_rom_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx
);

  always_comb begin
    int  c;
    logic found;
    c     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (en && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = CH_W'(c);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dds_rom_arbiter.sv
// Shares one async-read sine ROM among NUM_CH DDS channels; returns the
// registered sample, tagged with its channel, two cycles after the grant.
`default_nettype none

module dds_rom_arbiter
  import dds_rom_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
  parameter int ROM_WIDTH   = DDS_ROM_WIDTH,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [NUM_CH-1:0]             req_valid_i,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] req_phase_i,
  output logic [NUM_CH-1:0]             req_ready_o,
  output logic [PHASE_WIDTH-1:0]        rom_phase_o,
  input  logic [ROM_WIDTH-1:0]          rom_sin_i,
  output logic [NUM_CH-1:0]             rsp_valid_o,
  output logic [ROM_WIDTH-1:0]          rsp_sin_o,
  output logic [CH_W-1:0]               rsp_ch_o
);

  logic [CH_W-1:0]        ptr;
  logic [CH_W-1:0]        ptr_next;
  logic [NUM_CH-1:0]      grant;
  logic [CH_W-1:0]        grant_idx;
  logic                   fire;
  logic [PHASE_WIDTH-1:0] sel_phase;
  logic                   s1_vld;
  logic [CH_W-1:0]        s1_ch;

  // Grants are suppressed during reset so no handshake can complete then.
  dds_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .en    (en_i & ~rst_i),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready_o = grant;
  assign fire        = |grant;
  assign sel_phase   = req_phase_i[grant_idx*PHASE_WIDTH +: PHASE_WIDTH];
  assign ptr_next    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= ptr_next;
    end
  end

  // Address only moves on a transfer, keeping the ROM inputs quiet when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_phase_o <= '0;
      s1_ch       <= '0;
      s1_vld      <= 1'b0;
    end else begin
      s1_vld <= fire;
      if (fire) begin
        rom_phase_o <= sel_phase;
        s1_ch       <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_sin_o   <= '0;
      rsp_ch_o    <= '0;
    end else if (s1_vld) begin
      rsp_valid_o <= NUM_CH'(1) << s1_ch;
      rsp_sin_o   <= rom_sin_i;
      rsp_ch_o    <= s1_ch;
    end else begin
      rsp_valid_o <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dds_rom_arbiter.sv
// Directed bench for dds_rom_arbiter with a stand-in ROM: rom[a] = a[11:4] ^ 8'h3C.
`default_nettype none

module tb_dds_rom_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  req_valid_i;
  logic [47:0] req_phase_i;
  logic [3:0]  req_ready_o;
  logic [11:0] rom_phase_o;
  logic [7:0]  rom_sin_i;
  logic [3:0]  rsp_valid_o;
  logic [7:0]  rsp_sin_o;
  logic [1:0]  rsp_ch_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign rom_sin_i = rom_phase_o[11:4] ^ 8'h3C;

  dds_rom_arbiter #(
    .NUM_CH      (4),
    .PHASE_WIDTH (12),
    .ROM_WIDTH   (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .req_valid_i (req_valid_i),
    .req_phase_i (req_phase_i),
    .req_ready_o (req_ready_o),
    .rom_phase_o (rom_phase_o),
    .rom_sin_i   (rom_sin_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_sin_o   (rsp_sin_o),
    .rsp_ch_o    (rsp_ch_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hand-computed ROM words for phases 0x000,0x100,0x200,0x300
  logic [7:0]  sin_tab [4] = '{8'h3C, 8'h2C, 8'h1C, 8'h0C};
  logic [3:0]  oh_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [11:0] ph_tab  [4] = '{12'h000, 12'h100, 12'h200, 12'h300};

  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b1;
    req_valid_i = 4'hF;
    req_phase_i = {12'h300, 12'h200, 12'h100, 12'h000};

    // Reset held with all channels requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", req_ready_o, 4'b0000);
      chk("rst_rsp_valid", rsp_valid_o, 4'b0000);
      chk("rst_rom_phase", rom_phase_o, 12'h000);
    end
    chk("rst_rsp_sin", rsp_sin_o, 8'h00);
    chk("rst_rsp_ch", rsp_ch_o, 2'd0);
    rst_i = 1'b0;
    #1;

    // Full contention: strict rotation, responses two cycles later
    for (int i = 0; i < 8; i++) begin
      chk("rot_ready", req_ready_o, oh_tab[i % 4]);
      tick();
      chk("rot_rom_phase", rom_phase_o, ph_tab[i % 4]);
      if (i == 0) chk("rot_first_rsp_quiet", rsp_valid_o, 4'b0000);
      else begin
        chk("rot_rsp_valid", rsp_valid_o, oh_tab[(i - 1) % 4]);
        chk("rot_rsp_sin", rsp_sin_o, sin_tab[(i - 1) % 4]);
        chk("rot_rsp_ch", rsp_ch_o, (i - 1) % 4);
      end
    end
    req_valid_i = 4'b0000;
    tick();
    chk("rot_last_valid", rsp_valid_o, 4'b1000);
    chk("rot_last_sin", rsp_sin_o, 8'h0C);
    chk("idle_rom_hold", rom_phase_o, 12'h300);
    tick();
    chk("idle_rsp_valid", rsp_valid_o, 4'b0000);
    chk("idle_sin_hold", rsp_sin_o, 8'h0C);
    chk("idle_ch_hold", rsp_ch_o, 2'd3);

    // Single request on ch2, phase 0x400
    req_phase_i[2*12 +: 12] = 12'h400;
    req_valid_i = 4'b0100;
    #1;
    chk("single_ready", req_ready_o, 4'b0100);
    tick();
    req_valid_i = 4'b0000;
    chk("single_rom_phase", rom_phase_o, 12'h400);
    chk("single_no_rsp_yet", rsp_valid_o, 4'b0000);
    #1;
    chk("single_ready_off", req_ready_o, 4'b0000);
    tick();
    chk("single_rsp_valid", rsp_valid_o, 4'b0100);
    chk("single_rsp_sin", rsp_sin_o, 8'h7C);
    chk("single_rsp_ch", rsp_ch_o, 2'd2);

    // Park pointer at 1 with a lone ch0 grant (pointer was 3)
    req_valid_i = 4'b0001;
    #1;
    chk("park_ready", req_ready_o, 4'b0001);
    tick();
    req_valid_i = 4'b0000;
    tick();
    tick();

    // Fairness after a skip: ch3 then ch0, pointer ends at 1
    req_valid_i = 4'b1001;
    #1;
    chk("skip_ready_ch3", req_ready_o, 4'b1000);
    tick();
    req_valid_i = 4'b0001;
    #1;
    chk("skip_ready_ch0", req_ready_o, 4'b0001);
    tick();
    req_valid_i = 4'b0000;
    chk("skip_rsp_ch3", rsp_valid_o, 4'b1000);
    chk("skip_rsp_ch3_sin", rsp_sin_o, 8'h0C);
    req_valid_i = 4'hF;
    #1;
    chk("skip_ptr_is_1", req_ready_o, 4'b0010);
    req_valid_i = 4'b0000;
    tick();
    chk("skip_rsp_ch0", rsp_valid_o, 4'b0001);
    chk("skip_rsp_ch0_sin", rsp_sin_o, 8'h3C);
    tick();

    // Enable gating with two lookups in flight (ch1, ch2)
    req_valid_i = 4'hF;
    #1;
    chk("en_ready_ch1", req_ready_o, 4'b0010);
    tick();
    chk("en_ready_ch2", req_ready_o, 4'b0100);
    tick();
    en_i = 1'b0;
    #1;
    chk("en_off_ready", req_ready_o, 4'b0000);
    chk("en_inflight_ch1", rsp_valid_o, 4'b0010);
    chk("en_inflight_ch1_sin", rsp_sin_o, 8'h2C);
    tick();
    chk("en_inflight_ch2", rsp_valid_o, 4'b0100);
    chk("en_inflight_ch2_sin", rsp_sin_o, 8'h7C);
    chk("en_off_ready2", req_ready_o, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_off_ready_n", req_ready_o, 4'b0000);
      chk("en_off_rsp_n", rsp_valid_o, 4'b0000);
    end
    tick();
    en_i = 1'b1;
    #1;
    chk("en_resume_ptr3", req_ready_o, 4'b1000);

    // Reset one cycle after a ch1 transfer discards it
    req_valid_i = 4'b0010;
    #1;
    chk("mid_ready_ch1", req_ready_o, 4'b0010);
    tick();
    req_valid_i = 4'hF;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready_o, 4'b0000);
    tick();
    chk("mid_rom_phase", rom_phase_o, 12'h000);
    chk("mid_rsp_valid", rsp_valid_o, 4'b0000);
    chk("mid_rsp_sin", rsp_sin_o, 8'h00);
    chk("mid_rsp_ch", rsp_ch_o, 2'd0);
    rst_i = 1'b0;
    #1;
    chk("mid_next_grant", req_ready_o, 4'b0001);
    req_valid_i = 4'b0000;
    tick();
    chk("mid_discarded", rsp_valid_o, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
